// File: rtl/clip_record_controller_if.sv
// Sample-RAM port bundle between the clip controller and the single-port clip RAM.
//   mem_addr  : {clip, offset} address
//   mem_we    : write strobe, mem_wdata carries the sample
//   mem_re    : read strobe, mem_rdata is valid the cycle after mem_re
// master = controller side, slave = RAM side.
interface clip_record_controller_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 8
);
    logic [ADDR_W:0]   mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_re;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_addr,
        output mem_we,
        output mem_wdata,
        output mem_re,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_we,
        input  mem_wdata,
        input  mem_re,
        output mem_rdata
    );
endinterface

// File: rtl/clip_record_controller.sv
// Two-clip audio record/play sequencer driving a single-port sample RAM.
//   clock, reset        : system clock, asynchronous active-high reset
//   rec/play/stop_pulse : one-cycle commands from the button edge logic
//   clip_wr / clip_r    : clip selection, latched when a record / play starts
//   sample_tick         : sample-rate strobe; sample_in is the ADC sample
//   mem                 : sample RAM port (master side)
//   audio_out           : last played sample (held), audio_valid pulses on update
//   rec_busy/play_busy  : high while recording / playing
//   done                : one-cycle pulse on every return to idle
// All outputs are registered.
module clip_record_controller #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      rec_pulse,
    input  logic                      play_pulse,
    input  logic                      stop_pulse,
    input  logic                      clip_wr,
    input  logic                      clip_r,
    input  logic                      sample_tick,
    input  logic [DATA_W-1:0]         sample_in,
    clip_record_controller_if.master  mem,
    output logic [DATA_W-1:0]         audio_out,
    output logic                      audio_valid,
    output logic                      rec_busy,
    output logic                      play_busy,
    output logic                      done
);

    localparam int LenW = ADDR_W + 1;

    typedef enum logic [2:0] {
        StIdle,
        StRecWait,
        StRecWr,
        StPlayWait,
        StPlayRd,
        StPlayOut
    } state_e;

    state_e              state_q;
    logic                clip_q;
    logic [ADDR_W-1:0]   ptr_q;
    logic [ADDR_W:0]     len_q [2];
    logic [ADDR_W:0]     addr_q;
    logic                we_q;
    logic                re_q;
    logic [DATA_W-1:0]   wdata_q;

    assign mem.mem_addr  = addr_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_wdata = wdata_q;
    assign mem.mem_re    = re_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            clip_q      <= 1'b0;
            ptr_q       <= '0;
            len_q[0]    <= '0;
            len_q[1]    <= '0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            re_q        <= 1'b0;
            wdata_q     <= '0;
            audio_out   <= '0;
            audio_valid <= 1'b0;
            rec_busy    <= 1'b0;
            play_busy   <= 1'b0;
            done        <= 1'b0;
        end else begin
            // Strobes default low; each state raises the one it needs.
            we_q        <= 1'b0;
            re_q        <= 1'b0;
            audio_valid <= 1'b0;
            done        <= 1'b0;
            case (state_q)
                StIdle: begin
                    // Record wins over play; stop is meaningless here.
                    if (rec_pulse) begin
                        clip_q   <= clip_wr;
                        ptr_q    <= '0;
                        state_q  <= StRecWait;
                        rec_busy <= 1'b1;
                    end else if (play_pulse) begin
                        clip_q <= clip_r;
                        ptr_q  <= '0;
                        if (len_q[clip_r] == '0) begin
                            done <= 1'b1;
                        end else begin
                            state_q   <= StPlayWait;
                            play_busy <= 1'b1;
                        end
                    end
                end
                StRecWait: begin
                    // Stop beats a coincident tick: that sample is dropped.
                    if (stop_pulse) begin
                        len_q[clip_q] <= {1'b0, ptr_q};
                        state_q       <= StIdle;
                        rec_busy      <= 1'b0;
                        done          <= 1'b1;
                    end else if (sample_tick) begin
                        we_q    <= 1'b1;
                        addr_q  <= {clip_q, ptr_q};
                        wdata_q <= sample_in;
                        state_q <= StRecWr;
                    end
                end
                StRecWr: begin
                    // The write is on the bus this cycle; a stop here or a full
                    // clip counts it. A full clip yields len = 2**ADDR_W.
                    if (stop_pulse || (&ptr_q)) begin
                        len_q[clip_q] <= {1'b0, ptr_q} + LenW'(1);
                        state_q       <= StIdle;
                        rec_busy      <= 1'b0;
                        done          <= 1'b1;
                    end else begin
                        ptr_q   <= ptr_q + ADDR_W'(1);
                        state_q <= StRecWait;
                    end
                end
                StPlayWait: begin
                    if (stop_pulse) begin
                        state_q   <= StIdle;
                        play_busy <= 1'b0;
                        done      <= 1'b1;
                    end else if (sample_tick) begin
                        re_q    <= 1'b1;
                        addr_q  <= {clip_q, ptr_q};
                        state_q <= StPlayRd;
                    end
                end
                StPlayRd: begin
                    // Aborting here discards the read already issued.
                    if (stop_pulse) begin
                        state_q   <= StIdle;
                        play_busy <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        state_q <= StPlayOut;
                    end
                end
                StPlayOut: begin
                    // mem_rdata is valid now for the read issued last cycle.
                    audio_out   <= mem.mem_rdata;
                    audio_valid <= 1'b1;
                    if (stop_pulse || ({1'b0, ptr_q} == len_q[clip_q] - LenW'(1))) begin
                        state_q   <= StIdle;
                        play_busy <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        ptr_q   <= ptr_q + ADDR_W'(1);
                        state_q <= StPlayWait;
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    rec_busy  <= 1'b0;
                    play_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clip_record_controller.sv
// Bench for clip_record_controller: two instances (ADDR_W=14 and ADDR_W=3) share the
// stimulus; a selector picks which one is checked. Expected RAM traffic, audio and
// done pulses are derived from clip contents/lengths and keyed by cycle number.
module tb_clip_record_controller;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic rec_pulse = 1'b0, play_pulse = 1'b0, stop_pulse = 1'b0;
    logic clip_wr = 1'b0, clip_r = 1'b0, sample_tick = 1'b0;
    logic [7:0] sample_in = 8'h00;

    always #5 clock = ~clock;

    clip_record_controller_if #(.ADDR_W(14), .DATA_W(8)) mem_a ();
    clip_record_controller_if #(.ADDR_W(3),  .DATA_W(8)) mem_b ();

    logic [7:0] a_aout, b_aout;
    logic a_av, a_rb, a_pb, a_dn, b_av, b_rb, b_pb, b_dn;

    clip_record_controller #(.ADDR_W(14), .DATA_W(8)) dut_a (
        .clock(clock), .reset(reset), .rec_pulse(rec_pulse), .play_pulse(play_pulse),
        .stop_pulse(stop_pulse), .clip_wr(clip_wr), .clip_r(clip_r),
        .sample_tick(sample_tick), .sample_in(sample_in), .mem(mem_a),
        .audio_out(a_aout), .audio_valid(a_av), .rec_busy(a_rb), .play_busy(a_pb),
        .done(a_dn)
    );

    clip_record_controller #(.ADDR_W(3), .DATA_W(8)) dut_b (
        .clock(clock), .reset(reset), .rec_pulse(rec_pulse), .play_pulse(play_pulse),
        .stop_pulse(stop_pulse), .clip_wr(clip_wr), .clip_r(clip_r),
        .sample_tick(sample_tick), .sample_in(sample_in), .mem(mem_b),
        .audio_out(b_aout), .audio_valid(b_av), .rec_busy(b_rb), .play_busy(b_pb),
        .done(b_dn)
    );

    // Single-port sample RAMs, one-cycle read latency
    logic [7:0] ram_a [32768];
    logic [7:0] ram_b [16];
    always @(posedge clock) begin
        if (mem_a.mem_we) ram_a[mem_a.mem_addr] <= mem_a.mem_wdata;
        if (mem_a.mem_re) mem_a.mem_rdata <= ram_a[mem_a.mem_addr];
        if (mem_b.mem_we) ram_b[mem_b.mem_addr] <= mem_b.mem_wdata;
        if (mem_b.mem_re) mem_b.mem_rdata <= ram_b[mem_b.mem_addr];
    end

    // Selected DUT view
    logic sel = 1'b0;
    logic [14:0] c_addr;
    logic [7:0] c_wdata, c_aout;
    logic c_we, c_re, c_av, c_rb, c_pb, c_dn;
    always_comb begin
        c_addr = mem_a.mem_addr; c_wdata = mem_a.mem_wdata; c_we = mem_a.mem_we;
        c_re = mem_a.mem_re; c_aout = a_aout; c_av = a_av; c_rb = a_rb; c_pb = a_pb;
        c_dn = a_dn;
        if (sel) begin
            c_addr = {11'b0, mem_b.mem_addr}; c_wdata = mem_b.mem_wdata; c_we = mem_b.mem_we;
            c_re = mem_b.mem_re; c_aout = b_aout; c_av = b_av; c_rb = b_rb; c_pb = b_pb;
            c_dn = b_dn;
        end
    end

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Reference model: clip contents, lengths, and expected events per cycle
    int aw = 14;
    int depth = 1 << 14;
    int mlen [2];
    logic [7:0] mmem [2][16384];
    logic [22:0] exp_wr [int];
    logic [14:0] exp_rd [int];
    logic [7:0]  exp_av [int];
    bit          exp_dn [int];
    logic [7:0]  m_aout = 8'h00;
    bit mon_on = 1'b0;

    function automatic logic [14:0] maddr(input bit c, input int k);
        return 15'((int'(c) << aw) | k);
    endfunction

    always @(negedge clock) begin
        if (mon_on && !reset) begin
            if (exp_av.exists(cyc)) m_aout = exp_av[cyc];
            chk("mem_we", 32'(c_we), 32'(exp_wr.exists(cyc)));
            if (c_we && exp_wr.exists(cyc)) begin
                chk("wr_addr", 32'(c_addr), 32'(exp_wr[cyc][22:8]));
                chk("wr_data", 32'(c_wdata), 32'(exp_wr[cyc][7:0]));
            end
            chk("mem_re", 32'(c_re), 32'(exp_rd.exists(cyc)));
            if (c_re && exp_rd.exists(cyc)) chk("rd_addr", 32'(c_addr), 32'(exp_rd[cyc]));
            chk("audio_valid", 32'(c_av), 32'(exp_av.exists(cyc)));
            chk("audio_out", 32'(c_aout), 32'(m_aout));
            chk("done", 32'(c_dn), 32'(exp_dn.exists(cyc)));
            chk("we_re_excl", 32'(c_we & c_re), 32'd0);
        end
    end

    // Apply current inputs for one cycle; t is that cycle's number
    task automatic step(output int t);
        t = cyc;
        @(posedge clock);
        #1;
        rec_pulse = 1'b0; play_pulse = 1'b0; stop_pulse = 1'b0; sample_tick = 1'b0;
    endtask

    // Cycles where only stop matters; noise injects ignored pulses and ticks
    task automatic gap(input bit noise, input bit noise_tick, input int n);
        int t;
        for (int i = 0; i < n; i++) begin
            if (noise) begin
                rec_pulse = 1'($urandom); play_pulse = 1'($urandom);
                clip_wr = 1'($urandom); clip_r = 1'($urandom);
                sample_tick = noise_tick ? 1'($urandom) : 1'b0;
            end
            sample_in = 8'($urandom);
            step(t);
        end
    endtask

    task automatic chk_busy(input string nm, input bit rb, input bit pb);
        @(negedge clock);
        chk({nm, ".rec_busy"}, 32'(c_rb), 32'(rb));
        chk({nm, ".play_busy"}, 32'(c_pb), 32'(pb));
    endtask

    task automatic clear_model();
        exp_wr.delete(); exp_rd.delete(); exp_av.delete(); exp_dn.delete();
        mlen[0] = 0; mlen[1] = 0; m_aout = 8'h00;
    endtask

    task automatic do_reset();
        mon_on = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        clear_model();
        mon_on = 1'b1;
        @(negedge clock);
        chk("rst.mem_addr", 32'(c_addr), 0);
        chk("rst.mem_wdata", 32'(c_wdata), 0);
        chk("rst.audio_out", 32'(c_aout), 0);
        chk("rst.rec_busy", 32'(c_rb), 0);
        chk("rst.play_busy", 32'(c_pb), 0);
        chk("rst.done", 32'(c_dn), 0);
    endtask

    // mode 0: stop in wait after n ticks; 1: stop with the last write; 2: stop on last tick
    task automatic rec_op(input bit c, input int n, input int mode, input int base,
                          input bit noise);
        int t, cnt;
        bit full, ended;
        logic [7:0] s;
        rec_pulse = 1'b1; clip_wr = c;
        play_pulse = noise ? 1'($urandom) : 1'b0;
        clip_r = 1'($urandom);
        step(t);
        if (!noise) chk_busy("rec", 1'b1, 1'b0);
        cnt = 0; full = 0; ended = 0;
        for (int i = 0; i < n; i++) begin
            gap(noise && !full, 1'b0, noise ? int'($urandom_range(0, 2)) : 0);
            s = (base < 0) ? 8'($urandom) : 8'(base + i);
            if (i == n - 1 && mode == 2 && !full) begin
                stop_pulse = 1'b1; sample_tick = 1'b1; sample_in = s;
                step(t);
                exp_dn[t + 1] = 1'b1;
                mlen[c] = cnt;
                ended = 1;
                break;
            end
            sample_tick = 1'b1; sample_in = s;
            step(t);
            if (full) begin
                gap(1'b0, 1'b0, 1);
                continue;
            end
            exp_wr[t + 1] = {maddr(c, cnt), s};
            mmem[c][cnt] = s;
            cnt++;
            if (cnt == depth) begin
                full = 1; ended = 1;
                mlen[c] = depth;
                exp_dn[t + 2] = 1'b1;
                gap(noise, 1'b1, 1);
            end else if (i == n - 1 && mode == 1) begin
                stop_pulse = 1'b1;
                step(t);
                exp_dn[t + 1] = 1'b1;
                mlen[c] = cnt;
                ended = 1;
            end else begin
                gap(noise, 1'b1, 1);
            end
        end
        if (!ended || full) begin
            // After a full clip the controller is idle and this stop must do nothing
            stop_pulse = 1'b1;
            step(t);
            if (!ended) begin
                exp_dn[t + 1] = 1'b1;
                mlen[c] = cnt;
            end
        end
    endtask

    // stop_at: sample index at which to stop (-1 none); stop_rd: stop in read cycle
    task automatic play_op(input bit c, input int stop_at, input bit stop_rd, input bit noise);
        int t, t2;
        play_pulse = 1'b1; clip_r = c; clip_wr = 1'($urandom);
        step(t);
        if (mlen[c] == 0) begin
            exp_dn[t + 1] = 1'b1;
            if (!noise) chk_busy("play_empty", 1'b0, 1'b0);
            return;
        end
        if (!noise) chk_busy("play", 1'b0, 1'b1);
        for (int k = 0; k < mlen[c]; k++) begin
            gap(noise, 1'b0, noise ? int'($urandom_range(0, 2)) : 0);
            if (k == stop_at && !stop_rd) begin
                stop_pulse = 1'b1;
                step(t);
                exp_dn[t + 1] = 1'b1;
                return;
            end
            sample_tick = 1'b1;
            step(t);
            exp_rd[t + 1] = maddr(c, k);
            if (k == stop_at && stop_rd) begin
                stop_pulse = 1'b1;
                step(t2);
                exp_dn[t2 + 1] = 1'b1;
                return;
            end
            gap(noise, 1'b1, 2);
            exp_av[t + 3] = mmem[c][k];
            if (k == mlen[c] - 1) begin
                exp_dn[t + 3] = 1'b1;
                return;
            end
        end
    endtask

    typedef struct {
        bit rec, play, stop, cw, cr;
        bit rb, pb, dn;
    } vec_t;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [6];
        int t;
        tbl[0] = '{rec: 0, play: 1, stop: 0, cw: 0, cr: 0, rb: 0, pb: 0, dn: 1};
        tbl[1] = '{rec: 0, play: 0, stop: 1, cw: 0, cr: 0, rb: 0, pb: 0, dn: 0};
        tbl[2] = '{rec: 0, play: 1, stop: 0, cw: 0, cr: 1, rb: 0, pb: 1, dn: 0};
        tbl[3] = '{rec: 0, play: 1, stop: 1, cw: 0, cr: 0, rb: 0, pb: 0, dn: 1};
        tbl[4] = '{rec: 1, play: 1, stop: 0, cw: 0, cr: 1, rb: 1, pb: 0, dn: 0};
        tbl[5] = '{rec: 1, play: 0, stop: 1, cw: 1, cr: 0, rb: 1, pb: 0, dn: 0};

        // Reset state, then idle ticks must cause no RAM traffic
        do_reset();
        for (int i = 0; i < 10; i++) begin
            sample_tick = 1'b1;
            step(t);
            gap(1'b0, 1'b0, 1);
        end
        chk_busy("idle", 1'b0, 1'b0);

        // Record 0x10..0x14 into clip 1, stop, then play it back
        rec_op(1'b1, 5, 0, 'h10, 1'b0);
        chk("len1_after_rec", 32'(mlen[1]), 5);
        gap(1'b0, 1'b0, 1);
        play_op(1'b1, -1, 1'b0, 1'b0);
        gap(1'b0, 1'b0, 2);

        // Single-cycle command vectors from idle
        for (int i = 0; i < 6; i++) begin
            rec_pulse = tbl[i].rec; play_pulse = tbl[i].play; stop_pulse = tbl[i].stop;
            clip_wr = tbl[i].cw; clip_r = tbl[i].cr;
            step(t);
            if (tbl[i].dn) exp_dn[t + 1] = 1'b1;
            chk_busy($sformatf("tbl%0d", i), tbl[i].rb, tbl[i].pb);
            if (tbl[i].rb || tbl[i].pb) begin
                stop_pulse = 1'b1;
                step(t);
                exp_dn[t + 1] = 1'b1;
                if (tbl[i].rb) mlen[tbl[i].cw] = 0;
            end
            gap(1'b0, 1'b0, 1);
        end

        // Stop coincident with a tick drops that sample
        rec_op(1'b0, 4, 2, 'h30, 1'b0);
        play_op(1'b0, -1, 1'b0, 1'b0);
        // Stop during the write cycle keeps the write
        rec_op(1'b1, 4, 1, 'h40, 1'b0);
        play_op(1'b1, 2, 1'b1, 1'b0);
        play_op(1'b1, 1, 1'b0, 1'b0);
        play_op(1'b1, -1, 1'b0, 1'b0);
        gap(1'b0, 1'b0, 2);

        // Asynchronous reset between a tick and its write
        rec_pulse = 1'b1; clip_wr = 1'b1;
        step(t);
        gap(1'b0, 1'b0, 1);
        sample_tick = 1'b1; sample_in = 8'hA5;
        mon_on = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("async.rec_busy", 32'(c_rb), 0);
        chk("async.mem_we", 32'(c_we), 0);
        @(posedge clock);
        #1;
        sample_tick = 1'b0;
        chk("async.no_write", 32'(c_we), 0);
        chk("async.ram", 32'(ram_a[15'h4000]), 32'(mmem[1][0]));
        reset = 1'b0;
        clear_model();
        mon_on = 1'b1;
        play_op(1'b1, -1, 1'b0, 1'b0);
        gap(1'b0, 1'b0, 2);

        // Small clips: 10 ticks into an 8-deep clip auto-stop after the 8th
        sel = 1'b1; aw = 3; depth = 8;
        do_reset();
        rec_op(1'b0, 10, 0, 'h50, 1'b0);
        chk("len0_full", 32'(mlen[0]), 8);
        chk("ram_b_last", 32'(ram_b[7]), 32'h57);
        gap(1'b0, 1'b0, 1);
        play_op(1'b0, -1, 1'b0, 1'b0);
        gap(1'b0, 1'b0, 2);

        // Randomized operation mix with ignored-command noise
        for (int i = 0; i < 60; i++) begin
            bit c;
            c = 1'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                rec_op(c, int'($urandom_range(0, 11)), int'($urandom_range(0, 2)), -1, 1'b1);
            end else begin
                play_op(c, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1,
                        1'($urandom), 1'b1);
            end
            for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
                sample_tick = 1'($urandom);
                step(t);
            end
        end
        gap(1'b0, 1'b0, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
